friscv_axi_id_or_tracker: RTL and testbench

//  Per-ID AXI4 outstanding-request tracker for the read and write paths.

---
 rtl/friscv_axi_id_or_tracker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_friscv_axi_id_or_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_axi_id_or_tracker.sv
// ----------------------------------------------------------------------------
// friscv_axi_id_or_tracker
//
// Per-ID AXI4 outstanding-request tracker for a master port. Each accepted
// AW/AR request bumps a per-ID counter. The counter is released by the
// matching B response, or by the last R beat for reads. Per-ID full/pending
// flags let the master throttle issuance. Running totals and sticky
// overflow/underflow flags flag protocol abuse.
//
// Ports
//   aclk, aresetn, srst      clock, async active-low reset, sync reset
//   aw*/b*                   write request / response handshakes and IDs
//   ar*/r*, rlast            read request / data handshakes, IDs, last beat
//   err_clr                  one-cycle clear of the sticky error flags
//   wr_/rd_or_full           per-ID count == MAX_OR
//   wr_/rd_pending           per-ID count != 0
//   waiting_wr/rd_cpl        any ID pending
//   wr_/rd_or_total          sum of the per-ID counts
//   wr_/rd_ovf, wr_/rd_udf   sticky overflow / underflow
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// friscv_axi_id_or_cnt: one saturating up/down counter for a single ID.
// An increment and a decrement in the same cycle cancel out. A blocked
// increment (count at MAX_OR) reports ovf. A blocked decrement (count at 0)
// reports udf. The *_eff outputs mark the events that actually moved the
// count, so the totals can follow the counters exactly.
//   inc, dec            request / release for this ID this cycle
//   cnt                 registered count
//   inc_eff, dec_eff    count actually moves up / down this cycle
//   ovf, udf            blocked event this cycle (combinational)
// ----------------------------------------------------------------------------
module friscv_axi_id_or_cnt #(
    parameter int MAX_OR = 8,
    parameter int CNT_W  = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             inc_eff,
    output logic             dec_eff,
    output logic             ovf,
    output logic             udf
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OR);

    logic at_max;
    logic at_zero;

    assign at_max  = (cnt == MAX_C);
    assign at_zero = (cnt == '0);

    assign inc_eff = inc & ~dec & ~at_max;
    assign dec_eff = dec & ~inc & ~at_zero;
    assign ovf     = inc & ~dec &  at_max;
    assign udf     = dec & ~inc &  at_zero;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     cnt <= '0;
        else if (srst)    cnt <= '0;
        else if (inc_eff) cnt <= cnt + CNT_W'(1);
        else if (dec_eff) cnt <= cnt - CNT_W'(1);
    end

endmodule

// ----------------------------------------------------------------------------
// friscv_axi_id_or_dir: tracking for one direction (write or read).
// It holds the array of per-ID counters, the total and the sticky error
// flags. At most one increment and one decrement reach a direction per
// cycle, so the total moves by at most one.
//   inc_vld/inc_id      accepted request and its ID
//   dec_vld/dec_id      completed transaction and its ID
//   or_full, pending    per-ID decode of the registered counts
//   waiting             any ID pending
//   or_total            sum of counts
//   ovf, udf            sticky error flags
// ----------------------------------------------------------------------------
module friscv_axi_id_or_dir #(
    parameter        NAME     = "OR_Tracker",
    parameter        DIR      = "write",
    parameter int    MAX_OR   = 8,
    parameter int    AXI_ID_W = 2,
    parameter int    NB_ID    = 2**AXI_ID_W,
    parameter int    CNT_W    = $clog2(MAX_OR+1),
    parameter int    TOT_W    = $clog2(NB_ID*MAX_OR+1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                srst,
    input  logic                inc_vld,
    input  logic [AXI_ID_W-1:0] inc_id,
    input  logic                dec_vld,
    input  logic [AXI_ID_W-1:0] dec_id,
    input  logic                err_clr,
    output logic [NB_ID-1:0]    or_full,
    output logic [NB_ID-1:0]    pending,
    output logic                waiting,
    output logic [TOT_W-1:0]    or_total,
    output logic                ovf,
    output logic                udf
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OR);

    logic [NB_ID-1:0][CNT_W-1:0] cnt;
    logic [NB_ID-1:0]            inc_eff;
    logic [NB_ID-1:0]            dec_eff;
    logic [NB_ID-1:0]            ovf_id;
    logic [NB_ID-1:0]            udf_id;
    logic                        tot_inc;
    logic                        tot_dec;
    logic                        ovf_ev;
    logic                        udf_ev;

    for (genvar i = 0; i < NB_ID; i++) begin : g_id
        friscv_axi_id_or_cnt #(
            .MAX_OR (MAX_OR),
            .CNT_W  (CNT_W)
        ) u_cnt (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .inc     (inc_vld & (inc_id == AXI_ID_W'(i))),
            .dec     (dec_vld & (dec_id == AXI_ID_W'(i))),
            .cnt     (cnt[i]),
            .inc_eff (inc_eff[i]),
            .dec_eff (dec_eff[i]),
            .ovf     (ovf_id[i]),
            .udf     (udf_id[i])
        );

        assign or_full[i] = (cnt[i] == MAX_C);
        assign pending[i] = (cnt[i] != '0);
    end

    assign waiting = |pending;
    assign tot_inc = |inc_eff;
    assign tot_dec = |dec_eff;
    assign ovf_ev  = |ovf_id;
    assign udf_ev  = |udf_id;

    // An increment and a decrement on different IDs leave the total as is.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            or_total <= '0;
        end else if (srst) begin
            or_total <= '0;
        end else if (tot_inc && !tot_dec) begin
            or_total <= or_total + TOT_W'(1);
        end else if (tot_dec && !tot_inc) begin
            or_total <= or_total - TOT_W'(1);
        end
    end

    // A new error in the same cycle beats err_clr, so the error is not lost.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (srst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_ev)       ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
            if (udf_ev)       udf <= 1'b1;
            else if (err_clr) udf <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge aclk) begin
        if (aresetn && !srst) begin
            if (ovf_ev) $display("%s: %s overflow, id mask %b", NAME, DIR, ovf_id);
            if (udf_ev) $display("%s: %s underflow, id mask %b", NAME, DIR, udf_id);
        end
    end
`endif

endmodule

// ----------------------------------------------------------------------------
// Top: the write and read trackers run fully independently.
// ----------------------------------------------------------------------------
module friscv_axi_id_or_tracker #(
    parameter     NAME     = "OR_Tracker",
    parameter int MAX_OR   = 8,
    parameter int AXI_ID_W = 2
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic                                       srst,
    input  logic                                       awvalid,
    input  logic                                       awready,
    input  logic [AXI_ID_W-1:0]                        awid,
    input  logic                                       bvalid,
    input  logic                                       bready,
    input  logic [AXI_ID_W-1:0]                        bid,
    input  logic                                       arvalid,
    input  logic                                       arready,
    input  logic [AXI_ID_W-1:0]                        arid,
    input  logic                                       rvalid,
    input  logic                                       rready,
    input  logic [AXI_ID_W-1:0]                        rid,
    input  logic                                       rlast,
    input  logic                                       err_clr,
    output logic [2**AXI_ID_W-1:0]                     wr_or_full,
    output logic [2**AXI_ID_W-1:0]                     rd_or_full,
    output logic [2**AXI_ID_W-1:0]                     wr_pending,
    output logic [2**AXI_ID_W-1:0]                     rd_pending,
    output logic                                       waiting_wr_cpl,
    output logic                                       waiting_rd_cpl,
    output logic [$clog2((2**AXI_ID_W)*MAX_OR+1)-1:0]  wr_or_total,
    output logic [$clog2((2**AXI_ID_W)*MAX_OR+1)-1:0]  rd_or_total,
    output logic                                       wr_ovf,
    output logic                                       wr_udf,
    output logic                                       rd_ovf,
    output logic                                       rd_udf
);

    friscv_axi_id_or_dir #(
        .NAME     (NAME),
        .DIR      ("write"),
        .MAX_OR   (MAX_OR),
        .AXI_ID_W (AXI_ID_W)
    ) u_wr (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .inc_vld  (awvalid & awready),
        .inc_id   (awid),
        .dec_vld  (bvalid & bready),
        .dec_id   (bid),
        .err_clr  (err_clr),
        .or_full  (wr_or_full),
        .pending  (wr_pending),
        .waiting  (waiting_wr_cpl),
        .or_total (wr_or_total),
        .ovf      (wr_ovf),
        .udf      (wr_udf)
    );

    // Only the last beat of a read burst releases its ID.
    friscv_axi_id_or_dir #(
        .NAME     (NAME),
        .DIR      ("read"),
        .MAX_OR   (MAX_OR),
        .AXI_ID_W (AXI_ID_W)
    ) u_rd (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .inc_vld  (arvalid & arready),
        .inc_id   (arid),
        .dec_vld  (rvalid & rready & rlast),
        .dec_id   (rid),
        .err_clr  (err_clr),
        .or_full  (rd_or_full),
        .pending  (rd_pending),
        .waiting  (waiting_rd_cpl),
        .or_total (rd_or_total),
        .ovf      (rd_ovf),
        .udf      (rd_udf)
    );

endmodule

// File: tb/tb_friscv_axi_id_or_tracker.sv
// ----------------------------------------------------------------------------
// Testbench for friscv_axi_id_or_tracker. Directed scenarios, then biased
// random traffic, all compared every cycle against a per-ID count model.
// ----------------------------------------------------------------------------
module tb_friscv_axi_id_or_tracker;

    localparam int MAX_OR   = 8;
    localparam int AXI_ID_W = 2;
    localparam int NB_ID    = 4;
    localparam int TOT_W    = 6;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                srst, err_clr;
    logic                awvalid, awready, bvalid, bready;
    logic                arvalid, arready, rvalid, rready, rlast;
    logic [AXI_ID_W-1:0] awid, bid, arid, rid;
    logic [NB_ID-1:0]    wr_or_full, rd_or_full, wr_pending, rd_pending;
    logic                waiting_wr_cpl, waiting_rd_cpl;
    logic [TOT_W-1:0]    wr_or_total, rd_or_total;
    logic                wr_ovf, wr_udf, rd_ovf, rd_udf;

    friscv_axi_id_or_tracker #(
        .NAME("OR_Tracker"), .MAX_OR(MAX_OR), .AXI_ID_W(AXI_ID_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast),
        .err_clr(err_clr),
        .wr_or_full(wr_or_full), .rd_or_full(rd_or_full),
        .wr_pending(wr_pending), .rd_pending(rd_pending),
        .waiting_wr_cpl(waiting_wr_cpl), .waiting_rd_cpl(waiting_rd_cpl),
        .wr_or_total(wr_or_total), .rd_or_total(rd_or_total),
        .wr_ovf(wr_ovf), .wr_udf(wr_udf), .rd_ovf(rd_ovf), .rd_udf(rd_udf)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding count per direction (0=write, 1=read) and ID
    int cnt [2][NB_ID];
    bit m_ovf [2];
    bit m_udf [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NB_ID; i++) cnt[d][i] = 0;
            m_ovf[d] = 0;
            m_udf[d] = 0;
        end
    endtask

    task automatic dir_step(input int d, input bit inc, input int iid, input bit dec, input int did);
        bit o = 0;
        bit u = 0;
        if (!(inc && dec && iid == did)) begin
            if (inc) begin
                if (cnt[d][iid] == MAX_OR) o = 1;
                else cnt[d][iid]++;
            end
            if (dec) begin
                if (cnt[d][did] == 0) u = 1;
                else cnt[d][did]--;
            end
        end
        m_ovf[d] = o ? 1'b1 : (err_clr ? 1'b0 : m_ovf[d]);
        m_udf[d] = u ? 1'b1 : (err_clr ? 1'b0 : m_udf[d]);
    endtask

    task automatic model_step();
        if (srst) begin
            model_reset();
        end else begin
            dir_step(0, awvalid && awready, int'(awid), bvalid && bready, int'(bid));
            dir_step(1, arvalid && arready, int'(arid), rvalid && rready && rlast, int'(rid));
        end
    endtask

    task automatic check_all();
        int full [2];
        int pend [2];
        int tot [2];
        for (int d = 0; d < 2; d++) begin
            full[d] = 0; pend[d] = 0; tot[d] = 0;
            for (int i = 0; i < NB_ID; i++) begin
                if (cnt[d][i] == MAX_OR) full[d] |= (1 << i);
                if (cnt[d][i] != 0)      pend[d] |= (1 << i);
                tot[d] += cnt[d][i];
            end
        end
        chk("wr_or_full",     32'(wr_or_full),     32'(full[0]));
        chk("wr_pending",     32'(wr_pending),     32'(pend[0]));
        chk("waiting_wr_cpl", 32'(waiting_wr_cpl), 32'(pend[0] != 0));
        chk("wr_or_total",    32'(wr_or_total),    32'(tot[0]));
        chk("wr_ovf",         32'(wr_ovf),         32'(m_ovf[0]));
        chk("wr_udf",         32'(wr_udf),         32'(m_udf[0]));
        chk("rd_or_full",     32'(rd_or_full),     32'(full[1]));
        chk("rd_pending",     32'(rd_pending),     32'(pend[1]));
        chk("waiting_rd_cpl", 32'(waiting_rd_cpl), 32'(pend[1] != 0));
        chk("rd_or_total",    32'(rd_or_total),    32'(tot[1]));
        chk("rd_ovf",         32'(rd_ovf),         32'(m_ovf[1]));
        chk("rd_udf",         32'(rd_udf),         32'(m_udf[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_pending"},  32'(wr_pending),  32'd0);
        chk({tag, "_rd_pending"},  32'(rd_pending),  32'd0);
        chk({tag, "_wr_or_full"},  32'(wr_or_full),  32'd0);
        chk({tag, "_rd_or_full"},  32'(rd_or_full),  32'd0);
        chk({tag, "_wr_or_total"}, 32'(wr_or_total), 32'd0);
        chk({tag, "_rd_or_total"}, 32'(rd_or_total), 32'd0);
        chk({tag, "_errors"},      32'({wr_ovf, wr_udf, rd_ovf, rd_udf}), 32'd0);
        chk({tag, "_waiting"},     32'({waiting_wr_cpl, waiting_rd_cpl}), 32'd0);
    endtask

    task automatic drive(input bit aw, input int awi, input bit b, input int bi,
                         input bit ar, input int ari, input bit r, input int ri,
                         input bit rl);
        awvalid = aw; awready = aw; awid = AXI_ID_W'(awi);
        bvalid  = b;  bready  = b;  bid  = AXI_ID_W'(bi);
        arvalid = ar; arready = ar; arid = AXI_ID_W'(ari);
        rvalid  = r;  rready  = r;  rid  = AXI_ID_W'(ri);
        rlast   = rl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        srst = 1'b0;
        err_clr = 1'b0;
    endtask

    // Apply the current inputs for one clock edge, then compare.
    task automatic cycle();
        @(posedge aclk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_zero("reset");
        aresetn = 1'b1;
        cycle();

        // AW id1 x3 then B id1 x3
        repeat (3) begin drive(1, 1, 0, 0, 0, 0, 0, 0, 0); cycle(); end
        repeat (3) begin drive(0, 0, 1, 1, 0, 0, 0, 0, 0); cycle(); end
        idle(); cycle();

        // AR id2, four R beats with rlast on the last
        drive(0, 0, 0, 0, 1, 2, 0, 0, 0); cycle();
        for (int b = 0; b < 4; b++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 2, b == 3); cycle();
        end

        // Nine AW on id0: saturate, then clear the error
        repeat (9) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); end
        idle(); err_clr = 1'b1; cycle();
        idle(); cycle();
        repeat (8) begin drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle(); end

        // B on an empty id3
        drive(0, 0, 1, 3, 0, 0, 0, 0, 0); cycle();
        idle(); err_clr = 1'b1; cycle();

        // Same-ID and cross-ID inc/dec in one cycle
        repeat (2) begin drive(1, 1, 0, 0, 0, 0, 0, 0, 0); cycle(); end
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0); cycle();

        // Load every ID, then a one-cycle srst mid-traffic
        for (int i = 0; i < NB_ID; i++) begin drive(1, i, 0, 0, 1, i, 0, 0, 0); cycle(); end
        drive(1, 2, 0, 0, 1, 3, 1, 0, 1); srst = 1'b1; cycle();
        srst = 1'b0;

        // Biased random traffic: alternating fill-heavy and drain-heavy phases
        for (int n = 0; n < 4000; n++) begin
            int pi = ((n / 300) % 2 == 0) ? 75 : 25;
            int pd = 100 - pi;
            awvalid = ($urandom_range(0, 99) < pi);
            awready = ($urandom_range(0, 9) != 0);
            awid    = AXI_ID_W'($urandom_range(0, NB_ID-1));
            bvalid  = ($urandom_range(0, 99) < pd);
            bready  = ($urandom_range(0, 9) != 0);
            bid     = AXI_ID_W'($urandom_range(0, NB_ID-1));
            arvalid = ($urandom_range(0, 99) < pi);
            arready = ($urandom_range(0, 9) != 0);
            arid    = AXI_ID_W'($urandom_range(0, NB_ID-1));
            rvalid  = ($urandom_range(0, 99) < pd + 20);
            rready  = ($urandom_range(0, 9) != 0);
            rid     = AXI_ID_W'($urandom_range(0, NB_ID-1));
            rlast   = $urandom_range(0, 1);
            err_clr = ($urandom_range(0, 15) == 0);
            srst    = ($urandom_range(0, 299) == 0);
            cycle();

            // Occasional asynchronous reset pulse in the middle of a cycle
            if (n % 1000 == 999) begin
                idle();
                #2 aresetn = 1'b0;
                #1 check_zero("async");
                model_reset();
                #3 aresetn = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
